// File: rtl/tpu_seq_pkg.sv
// Shared types for the TPU instruction sequencer: opcodes, the 67-bit
// instruction word layout and the controller state encoding.
package tpu_seq_pkg;

    localparam int DRAIN_CYCLES_DEFAULT = 4;
    localparam int INSTR_W              = 67;

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_READ   = 3'd1,
        OP_SWITCH = 3'd2,
        OP_WAIT   = 3'd3,
        OP_SYNC   = 3'd4,
        OP_HALT   = 3'd5
    } opcode_e;

    typedef struct packed {
        opcode_e     opcode;
        logic        transpose;
        logic [8:0]  ptr_select;
        logic [15:0] addr;
        logic [15:0] row;
        logic [15:0] col;
        logic [3:0]  pathway;
        logic [1:0]  mode;
    } seq_instr_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WAIT,
        S_SYNC,
        S_DONE
    } state_e;

endpackage

// File: rtl/seq_imem.sv
// Instruction store for the sequencer: register-file array with a synchronous
// write port and a registered read port that doubles as the instruction register.
module seq_imem
    import tpu_seq_pkg::*;
#(
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  seq_instr_t    wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output seq_instr_t    rd_data_o
);

    seq_instr_t mem [DEPTH];
    seq_instr_t rdData_q;

    // Program contents survive reset so a loaded program can be re-run.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdData_q <= '0;
        end else if (rd_en_i) begin
            rdData_q <= mem[rd_addr_i];
        end
    end

    assign rd_data_o = rdData_q;

endmodule

// File: rtl/tpu_instr_sequencer.sv
// Program-driven controller that issues UB reads, weight switches, timed waits
// and VPU drain synchronisation from a host-loaded instruction memory.
module tpu_instr_sequencer
    import tpu_seq_pkg::*;
#(
    parameter int  IMEM_DEPTH           = 16,
    parameter int  DRAIN_CYCLES         = DRAIN_CYCLES_DEFAULT,
    parameter int  SYSTOLIC_ARRAY_WIDTH = 2,
    localparam int PCW                  = $clog2(IMEM_DEPTH)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            instr_wr_en,
    input  logic [PCW-1:0]                  instr_wr_addr,
    input  logic [INSTR_W-1:0]              instr_wr_data,
    input  logic                            start,
    input  logic                            abort,
    input  logic [SYSTOLIC_ARRAY_WIDTH-1:0] vpu_valid_in,
    output logic                            ub_rd_start_out,
    output logic                            ub_rd_transpose_out,
    output logic [8:0]                      ub_ptr_select_out,
    output logic [15:0]                     ub_rd_addr_out,
    output logic [15:0]                     ub_rd_row_size_out,
    output logic [15:0]                     ub_rd_col_size_out,
    output logic [3:0]                      vpu_data_pathway_out,
    output logic [1:0]                      sys_mode_out,
    output logic                            sys_switch_out,
    output logic                            busy,
    output logic                            done,
    output logic [PCW-1:0]                  pc_out
);

    state_e         state_q;
    logic [PCW-1:0] pc_q;
    logic [15:0]    wait_q;
    logic [15:0]    drain_q;
    logic           busy_q;
    logic           done_q;
    logic           ubRdStart_q;
    logic           sysSwitch_q;
    logic           ubRdTranspose_q;
    logic [8:0]     ubPtrSelect_q;
    logic [15:0]    ubRdAddr_q;
    logic [15:0]    ubRdRowSize_q;
    logic [15:0]    ubRdColSize_q;
    logic [3:0]     vpuPathway_q;
    logic [1:0]     sysMode_q;

    seq_instr_t     irData;
    logic           lastSlot;
    logic [PCW-1:0] advPc_d;
    state_e         advState_d;

    seq_imem #(
        .DEPTH(IMEM_DEPTH)
    ) u_imem (
        .clk_i    (clk),
        .rst_ni   (rst),
        .wr_en_i  (instr_wr_en & ~busy_q),
        .wr_addr_i(instr_wr_addr),
        .wr_data_i(seq_instr_t'(instr_wr_data)),
        .rd_en_i  (state_q == S_FETCH),
        .rd_addr_i(pc_q),
        .rd_data_o(irData)
    );

    // Retiring the last slot ends the program instead of wrapping the pc.
    always_comb begin
        lastSlot   = (pc_q == PCW'(IMEM_DEPTH - 1));
        advPc_d    = lastSlot ? pc_q : pc_q + PCW'(1);
        advState_d = lastSlot ? S_DONE : S_FETCH;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            pc_q            <= '0;
            wait_q          <= '0;
            drain_q         <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            ubRdStart_q     <= 1'b0;
            sysSwitch_q     <= 1'b0;
            ubRdTranspose_q <= 1'b0;
            ubPtrSelect_q   <= '0;
            ubRdAddr_q      <= '0;
            ubRdRowSize_q   <= '0;
            ubRdColSize_q   <= '0;
            vpuPathway_q    <= '0;
            sysMode_q       <= '0;
        end else begin
            ubRdStart_q <= 1'b0;
            sysSwitch_q <= 1'b0;
            done_q      <= 1'b0;
            if (abort && state_q != S_IDLE) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                wait_q  <= '0;
                drain_q <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start && !abort) begin
                            pc_q    <= '0;
                            busy_q  <= 1'b1;
                            state_q <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        state_q <= S_EXEC;
                    end
                    S_EXEC: begin
                        case (irData.opcode)
                            OP_NOP: begin
                                pc_q    <= advPc_d;
                                state_q <= advState_d;
                                done_q  <= lastSlot;
                            end
                            OP_READ: begin
                                ubRdStart_q     <= 1'b1;
                                ubRdTranspose_q <= irData.transpose;
                                ubPtrSelect_q   <= irData.ptr_select;
                                ubRdAddr_q      <= irData.addr;
                                ubRdRowSize_q   <= irData.row;
                                ubRdColSize_q   <= irData.col;
                                vpuPathway_q    <= irData.pathway;
                                sysMode_q       <= irData.mode;
                                pc_q            <= advPc_d;
                                state_q         <= advState_d;
                                done_q          <= lastSlot;
                            end
                            OP_SWITCH: begin
                                sysSwitch_q <= 1'b1;
                                pc_q        <= advPc_d;
                                state_q     <= advState_d;
                                done_q      <= lastSlot;
                            end
                            OP_WAIT: begin
                                if (irData.addr == 16'd0) begin
                                    pc_q    <= advPc_d;
                                    state_q <= advState_d;
                                    done_q  <= lastSlot;
                                end else begin
                                    wait_q  <= irData.addr;
                                    state_q <= S_WAIT;
                                end
                            end
                            OP_SYNC: begin
                                drain_q <= '0;
                                state_q <= S_SYNC;
                            end
                            default: begin
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end
                        endcase
                    end
                    S_WAIT: begin
                        if (wait_q == 16'd1) begin
                            wait_q  <= '0;
                            pc_q    <= advPc_d;
                            state_q <= advState_d;
                            done_q  <= lastSlot;
                        end else begin
                            wait_q <= wait_q - 16'd1;
                        end
                    end
                    S_SYNC: begin
                        // Any valid restarts the quiet-period count.
                        if (|vpu_valid_in) begin
                            drain_q <= '0;
                        end else if (drain_q == 16'(DRAIN_CYCLES - 1)) begin
                            drain_q <= '0;
                            pc_q    <= advPc_d;
                            state_q <= advState_d;
                            done_q  <= lastSlot;
                        end else begin
                            drain_q <= drain_q + 16'd1;
                        end
                    end
                    S_DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign ub_rd_start_out      = ubRdStart_q;
    assign ub_rd_transpose_out  = ubRdTranspose_q;
    assign ub_ptr_select_out    = ubPtrSelect_q;
    assign ub_rd_addr_out       = ubRdAddr_q;
    assign ub_rd_row_size_out   = ubRdRowSize_q;
    assign ub_rd_col_size_out   = ubRdColSize_q;
    assign vpu_data_pathway_out = vpuPathway_q;
    assign sys_mode_out         = sysMode_q;
    assign sys_switch_out       = sysSwitch_q;
    assign busy                 = busy_q;
    assign done                 = done_q;
    assign pc_out               = pc_q;

endmodule

// File: tb/tb_tpu_instr_sequencer.sv
// Bench for tpu_instr_sequencer: directed program scenarios plus random programs
// checked cycle-by-cycle against an instruction-level timing model.
module tb_tpu_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_wr_en;
    logic [3:0]  instr_wr_addr;
    logic [66:0] instr_wr_data;
    logic        start;
    logic        abort;
    logic [1:0]  vpu_valid_in;
    logic        ub_rd_start_out;
    logic        ub_rd_transpose_out;
    logic [8:0]  ub_ptr_select_out;
    logic [15:0] ub_rd_addr_out;
    logic [15:0] ub_rd_row_size_out;
    logic [15:0] ub_rd_col_size_out;
    logic [3:0]  vpu_data_pathway_out;
    logic [1:0]  sys_mode_out;
    logic        sys_switch_out;
    logic        busy;
    logic        done;
    logic [3:0]  pc_out;
    logic [63:0] cfgOut;

    int          compared   = 0;
    int          mismatched = 0;
    logic [66:0] prog [16];
    int          validSched [512];
    bit          expRead [512];
    bit          expSwitch [512];
    logic [63:0] readWord [512];

    tpu_instr_sequencer dut (
        .clk                 (clk),
        .rst                 (rst),
        .instr_wr_en         (instr_wr_en),
        .instr_wr_addr       (instr_wr_addr),
        .instr_wr_data       (instr_wr_data),
        .start               (start),
        .abort               (abort),
        .vpu_valid_in        (vpu_valid_in),
        .ub_rd_start_out     (ub_rd_start_out),
        .ub_rd_transpose_out (ub_rd_transpose_out),
        .ub_ptr_select_out   (ub_ptr_select_out),
        .ub_rd_addr_out      (ub_rd_addr_out),
        .ub_rd_row_size_out  (ub_rd_row_size_out),
        .ub_rd_col_size_out  (ub_rd_col_size_out),
        .vpu_data_pathway_out(vpu_data_pathway_out),
        .sys_mode_out        (sys_mode_out),
        .sys_switch_out      (sys_switch_out),
        .busy                (busy),
        .done                (done),
        .pc_out              (pc_out)
    );

    assign cfgOut = {ub_rd_transpose_out, ub_ptr_select_out, ub_rd_addr_out, ub_rd_row_size_out,
                     ub_rd_col_size_out, vpu_data_pathway_out, sys_mode_out};

    always #5 clk = ~clk;

    function automatic logic [66:0] mkInstr(input int op, input int tr, input int ptr, input int addr,
                                            input int row, input int col, input int path, input int mode);
        logic [66:0] w;
        w = {op[2:0], tr[0], ptr[8:0], addr[15:0], row[15:0], col[15:0], path[3:0], mode[1:0]};
        return w;
    endfunction

    task automatic clearSched();
        for (int e = 0; e < 512; e++) validSched[e] = 0;
    endtask

    // Edge k of a run is the k-th rising edge after the one that samples start.
    task automatic step(input int k);
        @(posedge clk);
        #1;
        if (k + 1 < 512) vpu_valid_in = 2'(validSched[k + 1]);
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < 16; i++) begin
            instr_wr_en   = 1'b1;
            instr_wr_addr = 4'(i);
            instr_wr_data = prog[i];
            @(posedge clk);
            #1;
        end
        instr_wr_en  = 1'b0;
        vpu_valid_in = 2'(validSched[0]);
        start        = 1'b1;
        @(posedge clk);
        #1;
        start        = 1'b0;
        vpu_valid_in = 2'(validSched[1]);
    endtask

    // Each instruction starts with its FETCH after edge c; its EXEC effects show after edge c+2.
    task automatic computeModel(output int doneEdge, output int lastPc);
        int c;
        int slot;
        int op;
        int e;
        int run;
        for (int i = 0; i < 512; i++) begin
            expRead[i]   = 1'b0;
            expSwitch[i] = 1'b0;
            readWord[i]  = '0;
        end
        c        = 0;
        slot     = 0;
        doneEdge = 0;
        lastPc   = 0;
        while (1'b1) begin
            op = int'(prog[slot][66:64]);
            if (op >= 5) begin
                doneEdge = c + 2;
                lastPc   = slot;
                break;
            end
            if (op == 1) begin
                expRead[c + 2]  = 1'b1;
                readWord[c + 2] = prog[slot][63:0];
                c += 2;
            end else if (op == 2) begin
                expSwitch[c + 2] = 1'b1;
                c += 2;
            end else if (op == 3) begin
                c += int'(prog[slot][53:38]) + 2;
            end else if (op == 4) begin
                e   = c + 2;
                run = 0;
                while (run < 4) begin
                    e++;
                    if (validSched[e] == 0) run++;
                    else run = 0;
                end
                c = e;
            end else begin
                c += 2;
            end
            if (slot == 15) begin
                doneEdge = c;
                lastPc   = 15;
                break;
            end
            slot++;
        end
    endtask

    task automatic test_reset();
        #12;
        compared++;
        if ({ub_rd_start_out, sys_switch_out, busy, done} !== 4'b0) begin
            mismatched++;
            $display("[TB] FAIL reset.pulses got %b exp 0000", {ub_rd_start_out, sys_switch_out, busy, done});
        end
        compared++;
        if (cfgOut !== 64'h0) begin
            mismatched++;
            $display("[TB] FAIL reset.config got %h exp 0", cfgOut);
        end
        compared++;
        if (pc_out !== 4'd0) begin
            mismatched++;
            $display("[TB] FAIL reset.pc got %0d exp 0", pc_out);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_read_halt();
        for (int i = 0; i < 16; i++) prog[i] = '0;
        prog[0] = mkInstr(1, 0, 1, 'h10, 2, 2, 8, 1);
        prog[1] = mkInstr(5, 0, 0, 0, 0, 0, 0, 0);
        clearSched();
        applyStimulus();
        for (int k = 1; k <= 7; k++) begin
            step(k);
            compared++;
            if (ub_rd_start_out !== (k == 2)) begin
                mismatched++;
                $display("[TB] FAIL read_halt.start k=%0d got %b exp %b", k, ub_rd_start_out, (k == 2));
            end
            compared++;
            if (done !== (k == 4)) begin
                mismatched++;
                $display("[TB] FAIL read_halt.done k=%0d got %b exp %b", k, done, (k == 4));
            end
            compared++;
            if (busy !== (k <= 4)) begin
                mismatched++;
                $display("[TB] FAIL read_halt.busy k=%0d got %b exp %b", k, busy, (k <= 4));
            end
            if (k >= 3) begin
                compared++;
                if (ub_rd_addr_out !== 16'h0010 || sys_mode_out !== 2'd1 || ub_ptr_select_out !== 9'd1 ||
                    ub_rd_row_size_out !== 16'd2 || ub_rd_col_size_out !== 16'd2 || vpu_data_pathway_out !== 4'b1000) begin
                    mismatched++;
                    $display("[TB] FAIL read_halt.config k=%0d got %h exp %h", k, cfgOut, prog[0][63:0]);
                end
            end
        end
        compared++;
        if (pc_out !== 4'd1) begin
            mismatched++;
            $display("[TB] FAIL read_halt.pc got %0d exp 1", pc_out);
        end
    endtask

    task automatic test_switch_wait();
        int swCount;
        for (int i = 0; i < 16; i++) prog[i] = '0;
        prog[0] = mkInstr(2, 0, 0, 0, 0, 0, 0, 0);
        prog[1] = mkInstr(3, 0, 0, 5, 0, 0, 0, 0);
        prog[2] = mkInstr(1, 0, 3, 'hABCD, 1, 1, 1, 2);
        prog[3] = mkInstr(5, 0, 0, 0, 0, 0, 0, 0);
        clearSched();
        swCount = 0;
        applyStimulus();
        for (int k = 1; k <= 17; k++) begin
            step(k);
            if (sys_switch_out === 1'b1) swCount++;
            compared++;
            if (sys_switch_out !== (k == 2)) begin
                mismatched++;
                $display("[TB] FAIL switch_wait.switch k=%0d got %b exp %b", k, sys_switch_out, (k == 2));
            end
            compared++;
            if (ub_rd_start_out !== (k == 11)) begin
                mismatched++;
                $display("[TB] FAIL switch_wait.read k=%0d got %b exp %b", k, ub_rd_start_out, (k == 11));
            end
            compared++;
            if (done !== (k == 13) || busy !== (k <= 13)) begin
                mismatched++;
                $display("[TB] FAIL switch_wait.done k=%0d got done=%b busy=%b exp done=%b busy=%b",
                         k, done, busy, (k == 13), (k <= 13));
            end
        end
        compared++;
        if (swCount != 1) begin
            mismatched++;
            $display("[TB] FAIL switch_wait.count got %0d exp 1", swCount);
        end
    endtask

    task automatic test_sync_drain();
        for (int i = 0; i < 16; i++) prog[i] = '0;
        prog[0] = mkInstr(4, 0, 0, 0, 0, 0, 0, 0);
        prog[1] = mkInstr(5, 0, 0, 0, 0, 0, 0, 0);
        clearSched();
        validSched[3] = 1;
        validSched[4] = 1;
        validSched[5] = 1;
        validSched[8] = 1;
        applyStimulus();
        for (int k = 1; k <= 16; k++) begin
            step(k);
            compared++;
            if (done !== (k == 14) || busy !== (k <= 14)) begin
                mismatched++;
                $display("[TB] FAIL sync_drain.done k=%0d got done=%b busy=%b exp done=%b busy=%b",
                         k, done, busy, (k == 14), (k <= 14));
            end
        end
    endtask

    task automatic test_abort();
        logic [63:0] cfg1;
        for (int i = 0; i < 16; i++) prog[i] = '0;
        prog[0] = mkInstr(1, 1, 'h1AB, 'h1234, 3, 5, 3, 2);
        prog[1] = mkInstr(3, 0, 0, 100, 0, 0, 0, 0);
        prog[2] = mkInstr(1, 0, 2, 'h5555, 7, 7, 5, 3);
        prog[3] = mkInstr(5, 0, 0, 0, 0, 0, 0, 0);
        cfg1 = prog[0][63:0];
        clearSched();
        applyStimulus();
        for (int k = 1; k <= 50; k++) begin
            step(k);
            abort = (k == 40);
            compared++;
            if (busy !== (k <= 40) || done !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL abort.busy k=%0d got busy=%b done=%b exp busy=%b done=0", k, busy, done, (k <= 40));
            end
            compared++;
            if (ub_rd_start_out !== (k == 2)) begin
                mismatched++;
                $display("[TB] FAIL abort.read k=%0d got %b exp %b", k, ub_rd_start_out, (k == 2));
            end
        end
        compared++;
        if (cfgOut !== cfg1) begin
            mismatched++;
            $display("[TB] FAIL abort.config_held got %h exp %h", cfgOut, cfg1);
        end
        applyStimulus();
        for (int k = 1; k <= 110; k++) begin
            step(k);
            compared++;
            if (ub_rd_start_out !== (k == 2 || k == 106)) begin
                mismatched++;
                $display("[TB] FAIL abort.rerun_read k=%0d got %b exp %b", k, ub_rd_start_out, (k == 2 || k == 106));
            end
            compared++;
            if (done !== (k == 108)) begin
                mismatched++;
                $display("[TB] FAIL abort.rerun_done k=%0d got %b exp %b", k, done, (k == 108));
            end
            if (k == 107) begin
                compared++;
                if (cfgOut !== prog[2][63:0]) begin
                    mismatched++;
                    $display("[TB] FAIL abort.rerun_config got %h exp %h", cfgOut, prog[2][63:0]);
                end
            end
        end
    endtask

    task automatic test_nop_full();
        for (int i = 0; i < 16; i++) prog[i] = '0;
        clearSched();
        applyStimulus();
        for (int k = 1; k <= 35; k++) begin
            step(k);
            instr_wr_en   = (k == 5);
            instr_wr_addr = 4'd3;
            instr_wr_data = mkInstr(5, 0, 0, 0, 0, 0, 0, 0);
            start         = (k == 9);
            compared++;
            if (done !== (k == 32) || busy !== (k <= 32)) begin
                mismatched++;
                $display("[TB] FAIL nop_full.done k=%0d got done=%b busy=%b exp done=%b busy=%b",
                         k, done, busy, (k == 32), (k <= 32));
            end
            if (k >= 32) begin
                compared++;
                if (pc_out !== 4'd15) begin
                    mismatched++;
                    $display("[TB] FAIL nop_full.pc k=%0d got %0d exp 15", k, pc_out);
                end
            end
        end
        instr_wr_en = 1'b0;
        start       = 1'b0;
    endtask

    task automatic test_start_abort_idle();
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            compared++;
            if (busy !== 1'b0 || ub_rd_start_out !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL start_abort_idle k=%0d got busy=%b read=%b exp 0 0", k, busy, ub_rd_start_out);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 16; i++) prog[i] = '0;
        prog[0] = mkInstr(1, 1, 'h1FF, 'hBEEF, 9, 9, 'hF, 3);
        prog[1] = mkInstr(5, 0, 0, 0, 0, 0, 0, 0);
        clearSched();
        applyStimulus();
        step(1);
        step(2);
        compared++;
        if (ub_rd_start_out !== 1'b1 || ub_rd_addr_out !== 16'hBEEF) begin
            mismatched++;
            $display("[TB] FAIL async_reset.pre got read=%b addr=%h exp 1 beef", ub_rd_start_out, ub_rd_addr_out);
        end
        #2;
        rst = 1'b0;
        #1;
        compared++;
        if (ub_rd_start_out !== 1'b0 || cfgOut !== 64'h0) begin
            mismatched++;
            $display("[TB] FAIL async_reset.outputs got read=%b cfg=%h exp 0 0", ub_rd_start_out, cfgOut);
        end
        compared++;
        if (busy !== 1'b0 || done !== 1'b0 || pc_out !== 4'd0) begin
            mismatched++;
            $display("[TB] FAIL async_reset.state got busy=%b done=%b pc=%0d exp 0 0 0", busy, done, pc_out);
        end
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random_programs();
        int          doneEdge;
        int          lastPc;
        int          r;
        bit          haveCfg;
        logic [63:0] cfg;
        for (int p = 0; p < 8; p++) begin
            clearSched();
            for (int e = 0; e < 300; e++)
                validSched[e] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            for (int i = 0; i < 16; i++) begin
                r = int'($urandom_range(0, 19));
                prog[i] = {$urandom, $urandom, $urandom};
                if (r <= 3 || r == 19) prog[i][66:64] = 3'd0;
                else if (r <= 9) prog[i][66:64] = 3'd1;
                else if (r <= 12) prog[i][66:64] = 3'd2;
                else if (r <= 15) begin
                    prog[i][66:64] = 3'd3;
                    prog[i][53:38] = 16'($urandom_range(0, 6));
                end else if (r <= 17) prog[i][66:64] = 3'd4;
                else prog[i][66:64] = 3'(5 + $urandom_range(0, 2));
            end
            computeModel(doneEdge, lastPc);
            applyStimulus();
            haveCfg = 1'b0;
            cfg     = '0;
            for (int k = 1; k <= doneEdge + 2; k++) begin
                step(k);
                compared++;
                if (ub_rd_start_out !== expRead[k] || sys_switch_out !== expSwitch[k]) begin
                    mismatched++;
                    $display("[TB] FAIL random.pulses p=%0d k=%0d got read=%b sw=%b exp read=%b sw=%b",
                             p, k, ub_rd_start_out, sys_switch_out, expRead[k], expSwitch[k]);
                end
                compared++;
                if (done !== (k == doneEdge) || busy !== (k <= doneEdge)) begin
                    mismatched++;
                    $display("[TB] FAIL random.done p=%0d k=%0d got done=%b busy=%b exp done=%b busy=%b",
                             p, k, done, busy, (k == doneEdge), (k <= doneEdge));
                end
                if (expRead[k]) begin
                    haveCfg = 1'b1;
                    cfg     = readWord[k];
                end
                if (haveCfg) begin
                    compared++;
                    if (cfgOut !== cfg) begin
                        mismatched++;
                        $display("[TB] FAIL random.config p=%0d k=%0d got %h exp %h", p, k, cfgOut, cfg);
                    end
                end
                if (k == doneEdge) begin
                    compared++;
                    if (pc_out !== 4'(lastPc)) begin
                        mismatched++;
                        $display("[TB] FAIL random.pc p=%0d got %0d exp %0d", p, pc_out, lastPc);
                    end
                end
            end
        end
    endtask

    initial begin
        rst           = 1'b0;
        instr_wr_en   = 1'b0;
        instr_wr_addr = '0;
        instr_wr_data = '0;
        start         = 1'b0;
        abort         = 1'b0;
        vpu_valid_in  = '0;
        clearSched();
        test_reset();
        test_read_halt();
        test_switch_wait();
        test_sync_drain();
        test_abort();
        test_nop_full();
        test_start_abort_idle();
        test_async_reset();
        test_random_programs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/tpu_instr_sequencer.md
Name: tpu_instr_sequencer

Overview:
- Small program-driven controller that sequences the TPU datapath (unified buffer read engine, systolic array, VPU) from a host-loaded instruction memory.
- Drives every TPU control port: UB read start/transpose/pointer select/address/row/column size, VPU data pathway, systolic switch and mode.
- Monitors VPU write-back valids to know when results have drained.
- Sits between the host/test harness and the TPU top level, replacing hand-driven control stimulus.

Parameters:
- IMEM_DEPTH, 16, instruction slots; program counter width is $clog2(IMEM_DEPTH).
- DRAIN_CYCLES, 4, consecutive cycles with both VPU valids low required to complete SYNC.
- SYSTOLIC_ARRAY_WIDTH, 2, number of VPU valid lanes monitored.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- instr_wr_en  in  1  host instruction write strobe
- instr_wr_addr  in  $clog2(IMEM_DEPTH)  write slot
- instr_wr_data  in  67  instruction word (seq_instr_t)
- start  in  1  begin execution at slot 0
- abort  in  1  synchronous stop
- vpu_valid_in  in  SYSTOLIC_ARRAY_WIDTH  VPU output valids
- ub_rd_start_out  out  1  one-cycle UB read start pulse
- ub_rd_transpose_out  out  1
- ub_ptr_select_out  out  9
- ub_rd_addr_out  out  16
- ub_rd_row_size_out  out  16
- ub_rd_col_size_out  out  16
- vpu_data_pathway_out  out  4
- sys_mode_out  out  2
- sys_switch_out  out  1  one-cycle weight switch pulse
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle completion pulse
- pc_out  out  $clog2(IMEM_DEPTH)  current slot

Behaviour:
- Reset (rst=0): all outputs 0, pc=0, state IDLE. Instruction memory contents are not reset.
- Instruction word fields, MSB to LSB:
  - opcode[66:64]
  - transpose[63]
  - ptr_select[62:54]
  - addr[53:38]
  - row[37:22]
  - col[21:6]
  - pathway[5:2]
  - mode[1:0]
- Opcodes: NOP=0, READ=1, SWITCH=2, WAIT=3, SYNC=4, HALT=5. Values 6 and 7 are treated as HALT.
- Writes are accepted only when busy=0; writes while busy are dropped.
- States: IDLE, FETCH, EXEC, WAIT, SYNC, DONE.
- IDLE:
  - start=1 sets pc=0 and moves to FETCH.
  - start is ignored when busy=1.
- FETCH: memory read at pc, registered into the instruction register (1 cycle); moves to EXEC.
- EXEC: decode.
  - NOP: pc+1, go to FETCH.
  - READ: next cycle, ub_rd_start_out=1 for exactly one cycle. transpose, ptr_select, addr, row, col, pathway and mode are registered on the same edge and held until the next READ or reset. Then pc+1, go to FETCH.
  - SWITCH: sys_switch_out=1 for one cycle, pc+1, go to FETCH.
  - WAIT: load a 16-bit counter with addr. If addr=0, go directly to FETCH (pc+1). Otherwise stay in WAIT for exactly addr cycles, then pc+1 and go to FETCH.
  - SYNC: clear the drain counter and go to SYNC.
  - HALT: go to DONE.
- SYNC state:
  - Counter increments each cycle with vpu_valid_in==0 and resets to 0 on any valid high.
  - On reaching DRAIN_CYCLES: pc+1, go to FETCH.
- Program end: after executing slot IMEM_DEPTH-1, pc does not wrap; a non-HALT instruction there is followed by DONE.
- DONE: done=1 for one cycle, busy=0 from the next cycle, go to IDLE. pc_out holds the last slot.
- Timing:
  - start sampled at edge t → first READ pulse at cycle t+3.
  - Back-to-back READs pulse every 2 cycles.
  - WAIT n costs n+2 cycles including FETCH and EXEC.
- abort=1 in any non-IDLE state: next cycle is IDLE, counters and pulse outputs cleared, held config outputs unchanged, no done pulse. abort has priority over start and over opcode execution.
- start and abort together in IDLE: abort wins and the sequencer stays in IDLE.
- Asynchronous reset mid-program forces IDLE and zeroes outputs immediately.

Decomposition:
- Package tpu_seq_pkg:
  - opcode_e enum
  - seq_instr_t packed struct (67 bits, field order above)
  - state_e enum
  - DRAIN_CYCLES_DEFAULT constant
- One sub-module, seq_imem: IMEM_DEPTH x 67 register-file memory with a synchronous write port and a registered read port.
- FSM and output registers live in the top module.

Test Plan:
- Program [READ addr=0x0010 row=2 col=2 ptr=1 pathway=4'b1000 mode=1, HALT]; start at t → ub_rd_start_out high only at t+3, ub_rd_addr_out=0x0010, sys_mode_out=1 held after the pulse; done pulses at t+5; busy low at t+6.
- Program [SWITCH, WAIT 5, READ, HALT] → sys_switch_out at t+3; READ pulse at t+3+2+7=t+12; exactly one switch pulse.
- Program [SYNC, HALT] with vpu_valid_in=2'b01 for 3 cycles, low 2 cycles, 01 again, then low → done only after 4 consecutive low cycles.
- Program with WAIT 100; assert abort mid-wait → busy low next cycle, no done, config outputs retain the last READ values; a later start re-runs from slot 0.
- Full 16-slot program of NOPs with no HALT → done after slot 15, pc_out=15. A write during the run leaves memory unchanged; start asserted while busy is ignored.
- Asynchronous reset asserted between clock edges during READ issue → ub_rd_start_out and all config outputs drop to 0 immediately.
